// File: rtl/ternary_neuron_accum_if.sv
// Beat-in / result-out handshake bundle for the ternary neuron accumulator.
// The slave side is the accumulator; the master side is its upstream/downstream environment.
interface ternary_neuron_accum_if #(
  parameter int PC_W  = 5,
  parameter int ACC_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PC_W-1:0]         pc_pos;
  logic [PC_W-1:0]         pc_neg;
  logic signed [ACC_W-1:0] thr;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_act;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_sat;

  modport slave (
    input  in_valid, pc_pos, pc_neg, thr, out_ready,
    output in_ready, out_valid, out_act, out_sum, out_sat
  );

  modport master (
    output in_valid, pc_pos, pc_neg, thr, out_ready,
    input  in_ready, out_valid, out_act, out_sum, out_sat
  );
endinterface

// File: rtl/ternary_neuron_accum.sv
// Ternary neuron back end: saturating accumulation of (pc_pos - pc_neg) over a
// CHUNKS-beat frame, thresholded into a 1-bit activation held until consumed.
module ternary_neuron_accum #(
  parameter int PC_W   = 5,
  parameter int CHUNKS = 5,
  parameter int ACC_W  = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  ternary_neuron_accum_if.slave bus
);
  localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0]      LAST    = CNT_W'(CHUNKS - 1);
  localparam logic signed [ACC_W:0] WIDE_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] WIDE_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]      SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]      SAT_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q, thr_q, sum_q;
  logic                    sat_q, in_ready_q, out_valid_q, act_q, osat_q;

  logic                    first, accept, ovf_hi, ovf_lo, sticky_d, act_d;
  logic signed [PC_W:0]    diff;
  logic signed [ACC_W:0]   diff_x, base, nxt;
  logic signed [ACC_W-1:0] sat_d, thr_d;

  // One extra accumulator bit is enough: |diff| < 2^PC_W <= 2^(ACC_W-1).
  always_comb begin
    first    = (cnt_q == '0);
    accept   = bus.in_valid & in_ready_q;
    diff     = $signed({1'b0, bus.pc_pos}) - $signed({1'b0, bus.pc_neg});
    diff_x   = {{(ACC_W-PC_W){diff[PC_W]}}, diff};
    base     = first ? '0 : {acc_q[ACC_W-1], acc_q};
    nxt      = base + diff_x;
    ovf_hi   = (nxt > WIDE_MAX);
    ovf_lo   = (nxt < WIDE_MIN);
    sat_d    = ovf_hi ? SAT_MAX : (ovf_lo ? SAT_MIN : nxt[ACC_W-1:0]);
    // The first beat of a frame supplies its own threshold and a clean sticky flag.
    thr_d    = first ? bus.thr : thr_q;
    sticky_d = (first ? 1'b0 : sat_q) | ovf_hi | ovf_lo;
    act_d    = (sat_d >= thr_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      thr_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      act_q       <= 1'b0;
      sum_q       <= '0;
      osat_q      <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: if (accept) begin
          thr_q <= thr_d;
          if (cnt_q == LAST) begin
            sum_q       <= sat_d;
            act_q       <= act_d;
            osat_q      <= sticky_d;
            cnt_q       <= '0;
            state_q     <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            acc_q <= sat_d;
            sat_q <= sticky_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: if (bus.out_ready) begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          acc_q       <= '0;
          sat_q       <= 1'b0;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_act   = act_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_sat   = osat_q;
endmodule

// File: doc/ternary_neuron_accum.md
Name: ternary_neuron_accum

Overview:
- Sequential ternary-neuron back end, directly downstream of the 30-input popcount stages.
- Each neuron frame is CHUNKS beats. Every beat carries two popcounts:
  - pc_pos: popcount of the +1-weight inputs.
  - pc_neg: popcount of the -1-weight inputs.
- The block accumulates pc_pos - pc_neg with saturation, compares the sum against a per-frame threshold, and emits a 1-bit activation plus the sum over a valid/ready handshake.
- It sits between the popcount tree and the next printed-NN layer's input register.

Parameters:
- PC_W, 5, popcount width; matches the popcount30 output width.
- CHUNKS, 5, beats per neuron frame; minimum 1.
- ACC_W, 8, signed accumulator, threshold and sum width; must be at least PC_W+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- in_valid  input  1  beat present on pc_pos/pc_neg/thr.
- in_ready  output  1  block can accept a beat.
- pc_pos  input  PC_W  unsigned popcount of the positive-weight inputs.
- pc_neg  input  PC_W  unsigned popcount of the negative-weight inputs.
- thr  input  ACC_W  signed threshold; sampled only on the first beat of a frame.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_act  output  1  activation: 1 when sum >= threshold (signed compare).
- out_sum  output  ACC_W  signed saturated sum.
- out_sat  output  1  saturation occurred at any point in the frame.

Behaviour:
- Reset: clk edge with rst_n=0. After reset:
  - state=ACCUM, beat count=0, acc=0, thr_q=0, sat_q=0.
  - in_ready=1, out_valid=0, out_act=0, out_sum=0, out_sat=0.
  - Reset overrides everything, including a mid-frame state or a pending result; any partial frame is discarded.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1; out_act, out_sum and out_sat are stable.
- Beat accept: in_valid & in_ready at a rising edge.
  - diff = pc_pos - pc_neg, computed signed at PC_W+1 bits and sign-extended to ACC_W+1.
  - nxt = acc + diff, computed at ACC_W+1 bits.
  - Saturation: if nxt > 2^(ACC_W-1)-1, clamp to 2^(ACC_W-1)-1. If nxt < -2^(ACC_W-1), clamp to -2^(ACC_W-1). Either clamp sets the sticky sat flag.
  - On the first beat (count=0), thr is captured into thr_q, and the accumulation starts from 0. The old acc value and the sticky flag are ignored.
- Non-final beat (count < CHUNKS-1): acc <= sat(nxt), count++, remain in ACCUM.
- Final beat (count = CHUNKS-1):
  - out_sum <= sat(nxt).
  - out_act <= (sat(nxt) >= thr_q), where thr_q is this frame's threshold. When CHUNKS=1, the value captured on that same beat is used.
  - out_sat <= sticky OR this beat's saturation.
  - count <= 0, state <= HOLD.
  - out_valid rises the cycle after the final beat is accepted; latency is 1 cycle.
- HOLD exit:
  - When out_valid & out_ready: return to ACCUM, with acc=0 and sticky=0.
  - in_ready rises in the next cycle. There is no same-cycle input accept during the HOLD release.
  - out_sum, out_act and out_sat keep their values until the next final beat; only out_valid qualifies them.
- Back-pressure:
  - In HOLD, in_valid is ignored and beats are not consumed; the upstream must hold them.
  - Maximum throughput is one frame per CHUNKS+1 cycles when out_ready is tied to 1.
- Stall: in_valid=0 in ACCUM leaves all state unchanged. Gaps between beats are allowed.
- Stuck input: out_ready=0 held indefinitely keeps HOLD with stable outputs.

Test Plan:
- Reset then one full frame:
  - Stimulus: thr=3; beats (pos,neg) = (10,2), (4,4), (0,6), (7,1), (5,5).
  - Required: sum=8, out_act=1, out_sat=0.
  - out_valid is high exactly 1 cycle after beat 5; in_ready=0 while it is held.
- Positive saturation:
  - Stimulus: five beats of (31,0), thr=0.
  - Required: acc clamps at 127 on beat 5 (155 > 127); out_sum=127, out_sat=1, out_act=1.
- Negative saturation and threshold:
  - Stimulus: five beats of (0,31), thr=-128.
  - Required: out_sum=-128, out_sat=1, out_act=1 (equality passes).
  - Repeat with thr=-127: out_act=0.
- Handshake:
  - Stimulus: out_ready=0 for 10 cycles after a frame, with in_valid held at 1.
  - Required: no beat is consumed and the outputs stay stable. out_ready=1 returns the block to ACCUM.
  - The next frame starts from acc=0, its sticky flag is clear, and its thr value is newly sampled.
- Gaps and reset mid-frame:
  - Stimulus: in_valid toggled 1-0-1 for 3 beats of (3,1), then rst_n=0 for 1 cycle.
  - Required: out_valid=0 and in_ready=1.
  - A following full frame of five (1,0) beats gives sum=5 and no contribution from the pre-reset beats.
- CHUNKS=1 variant:
  - Stimulus: beat (2,9), thr=-7.
  - Required: out_sum=-7, out_act=1, result the next cycle.
